adder_share_ctrl: RTL and testbench

//   Sequencer and 2-way round-robin arbiter for the shared A/B/S operand-register + 8-bit adder datapath.
//   Two requesters present operand pairs with a req/ack handshake; the block grants one,

---
 rtl/adder_share_ctrl.sv | 134 +++++++++++++
 tb/tb_adder_share_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
// Sequencer and 2-way round-robin arbiter for the shared A/B/S operand registers and adder.
// Optional build macro ADD_SAT_EN clamps the stored sum to all-ones on overflow.
module adder_share_ctrl #(
    parameter int W = 8
) (
    input  logic         CLOCK_50,
    input  logic         RESET,
    input  logic [1:0]   REQ,
    input  logic [W-1:0] OPA0,
    input  logic [W-1:0] OPB0,
    input  logic [W-1:0] OPA1,
    input  logic [W-1:0] OPB1,
    output logic [1:0]   ACK,
    output logic         GNT_ID,
    output logic         BUSY,
    output logic [W-1:0] A_Q,
    output logic [W-1:0] B_Q,
    output logic [W:0]   S_Q,
    output logic [2:0]   STATE_Q
);

    // state  | meaning
    // IDLE   | wait for a request, arbitrate
    // LOAD_A | A_Q <= winner's operand A
    // LOAD_B | B_Q <= winner's operand B
    // ADD    | S_Q <= A_Q + B_Q
    // DONE   | ACK pulse to winner, remember it for the next tie
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_A = 3'd1;
    localparam logic [2:0] LOAD_B = 3'd2;
    localparam logic [2:0] ADD    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]   state_q;
    logic [2:0]   state_d;
    logic         gnt_q;
    logic         last_q;
    logic         pick;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W:0]   s_q;
    logic [W:0]   sum_raw;
    logic [W:0]   sum_val;
    logic [1:0]   ack_q;
    logic         ld_gnt;
    logic         ld_a;
    logic         ld_b;
    logic         ld_s;
    logic         ld_last;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = (REQ != 2'b00) ? LOAD_A : IDLE;
            LOAD_A:  state_d = LOAD_B;
            LOAD_B:  state_d = ADD;
            ADD:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_gnt  = 1'b0;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_s    = 1'b0;
        ld_last = 1'b0;
        case (state_q)
            IDLE:    ld_gnt  = |REQ;
            LOAD_A:  ld_a    = 1'b1;
            LOAD_B:  ld_b    = 1'b1;
            ADD:     ld_s    = 1'b1;
            DONE:    ld_last = 1'b1;
            default: ;
        endcase
    end

    // A tie goes to whichever requester was not served last.
    assign pick    = (REQ == 2'b11) ? ~last_q : REQ[1];
    assign sum_raw = {1'b0, a_q} + {1'b0, b_q};

`ifdef ADD_SAT_EN
    assign sum_val = sum_raw[W] ? {(W+1){1'b1}} : sum_raw;
`else
    assign sum_val = sum_raw;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            gnt_q  <= 1'b0;
            last_q <= 1'b1;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            ack_q  <= 2'b00;
        end else begin
            ack_q <= 2'b00;
            if (ld_gnt) begin
                gnt_q <= pick;
            end
            if (ld_a) begin
                a_q <= gnt_q ? OPA1 : OPA0;
            end
            if (ld_b) begin
                b_q <= gnt_q ? OPB1 : OPB0;
            end
            if (ld_s) begin
                s_q   <= sum_val;
                ack_q <= gnt_q ? 2'b10 : 2'b01;
            end
            if (ld_last) begin
                last_q <= gnt_q;
            end
        end
    end

    assign ACK     = ack_q;
    assign GNT_ID  = gnt_q;
    assign BUSY    = (state_q != IDLE);
    assign A_Q     = a_q;
    assign B_Q     = b_q;
    assign S_Q     = s_q;
    assign STATE_Q = state_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: directed literal cases, then random requesters checked
// every cycle against an operation-progress model of the arbiter/sequencer.
module tb_adder_share_ctrl;

`ifdef ADD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] opa0, opb0, opa1, opb1;
    logic [1:0] ack;
    logic       gnt_id, busy;
    logic [7:0] a_q, b_q;
    logic [8:0] s_q;
    logic [2:0] state_q;

    int total = 0;
    int bad = 0;

    adder_share_ctrl #(.W(8)) dut (
        .CLOCK_50(clk), .RESET(rst), .REQ(req),
        .OPA0(opa0), .OPB0(opb0), .OPA1(opa1), .OPB1(opb1),
        .ACK(ack), .GNT_ID(gnt_id), .BUSY(busy),
        .A_Q(a_q), .B_Q(b_q), .S_Q(s_q), .STATE_Q(state_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'(a) + int'(b);
        if (SAT && s > 255) s = 511;
        return 9'(s);
    endfunction

    // Model: age of the current operation in cycles since the grant (0 = none in flight).
    int         m_age = 0;
    bit         m_valid = 1'b0;
    bit         m_gnt = 1'b0;
    bit         m_last = 1'b1;
    logic [7:0] m_a = '0, m_b = '0;
    logic [8:0] m_s = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_age   <= 0;
            m_gnt   <= 1'b0;
            m_last  <= 1'b1;
            m_a     <= '0;
            m_b     <= '0;
            m_s     <= '0;
        end else if (m_age == 0) begin
            if (req != 2'b00) begin
                m_gnt <= (req == 2'b11) ? !m_last : req[1];
                m_age <= 1;
            end
        end else begin
            if (m_age == 1) m_a <= m_gnt ? opa1 : opa0;
            if (m_age == 2) m_b <= m_gnt ? opb1 : opb0;
            if (m_age == 3) m_s <= ref_sum(m_a, m_b);
            if (m_age == 4) m_last <= m_gnt;
            m_age <= (m_age == 4) ? 0 : m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("ack",   32'(ack),     (m_age == 4) ? (m_gnt ? 32'd2 : 32'd1) : 32'd0);
            check("busy",  32'(busy),    32'(m_age != 0));
            check("state", 32'(state_q), 32'(m_age));
            check("gnt",   32'(gnt_id),  32'(m_gnt));
            check("a_q",   32'(a_q),     32'(m_a));
            check("b_q",   32'(b_q),     32'(m_b));
            check("s_q",   32'(s_q),     32'(m_s));
        end
    end

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 2'b00 && n < 30);
    endtask

    initial begin
        int n;
        rst = 1'b1; req = 2'b00;
        opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;

        check("pin_sum_plain", 32'(ref_sum(8'h12, 8'h34)), 32'h046);
        check("pin_sum_ovf",   32'(ref_sum(8'hFF, 8'h02)), SAT ? 32'h1FF : 32'h101);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ack", 32'(ack), 32'd0);
        check("idle_a", 32'(a_q), 32'd0);
        check("idle_b", 32'(b_q), 32'd0);
        check("idle_s", 32'(s_q), 32'd0);
        check("idle_state", 32'(state_q), 32'd0);

        opa0 = 8'h12; opb0 = 8'h34; req = 2'b01;
        wait_ack(n);
        check("single_lat", 32'(n), 32'd4);
        check("single_ack", 32'(ack), 32'd1);
        check("single_s", 32'(s_q), 32'h046);
        check("single_gnt", 32'(gnt_id), 32'd0);
        req = 2'b00;
        @(negedge clk);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        opa0 = 8'h01; opb0 = 8'h02; opa1 = 8'h10; opb1 = 8'h20; req = 2'b11;
        wait_ack(n);
        check("tie_first_lat", 32'(n), 32'd4);
        check("tie_first_ack", 32'(ack), 32'd1);
        check("tie_first_s", 32'(s_q), 32'h003);
        req[0] = 1'b0;
        wait_ack(n);
        check("tie_second_lat", 32'(n), 32'd5);
        check("tie_second_ack", 32'(ack), 32'd2);
        check("tie_second_s", 32'(s_q), 32'h030);
        check("tie_second_gnt", 32'(gnt_id), 32'd1);
        req = 2'b00;
        @(negedge clk);

        opa1 = 8'hFF; opb1 = 8'h02; req = 2'b10;
        wait_ack(n);
        check("ovf_lat", 32'(n), 32'd4);
        check("ovf_ack", 32'(ack), 32'd2);
        check("ovf_s", 32'(s_q), SAT ? 32'h1FF : 32'h101);
        req = 2'b00;
        @(negedge clk);

        opa0 = 8'h55; opb0 = 8'h22; req = 2'b01;
        repeat (2) @(negedge clk);
        check("abort_in_load_b", 32'(state_q), 32'd2);
        check("abort_a_loaded", 32'(a_q), 32'h55);
        rst = 1'b1; req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", 32'(state_q), 32'd0);
        check("abort_a", 32'(a_q), 32'd0);
        check("abort_b", 32'(b_q), 32'd0);
        check("abort_s", 32'(s_q), 32'd0);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack != 2'b00) n++;
        end
        check("abort_no_ack", 32'(n), 32'd0);

        opa0 = 8'h70; opb0 = 8'h0F; req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        wait_ack(n);
        check("drop_lat", 32'(n), 32'd3);
        check("drop_ack", 32'(ack), 32'd1);
        check("drop_s", 32'(s_q), 32'h07F);
        @(negedge clk);
        check("drop_busy_after", 32'(busy), 32'd0);

        repeat (3000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < 2; i++) begin
                if (req[i] && ack[i]) begin
                    req[i] = 1'b0;
                end else if (req[i]) begin
                    if ($urandom_range(0, 63) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    if (i == 0) begin
                        opa0 = 8'($urandom); opb0 = 8'($urandom);
                    end else begin
                        opa1 = 8'($urandom); opb1 = 8'($urandom);
                    end
                    req[i] = 1'b1;
                end
            end
        end
        rst = 1'b0; req = 2'b00;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
